// File: rtl/apb_slv_regbank.sv
`default_nettype none
// ============================================================================
// Module  : apb_slv_regbank
// Brief   : Zero-wait-state APB responder with R/W registers, status,
//           write counter and cycle counter. Define APB_SLV_PROT_CHK_EN to
//           add the sticky proto_err protocol checker.
// Revision: 1.0 - initial release
// ============================================================================
module apb_slv_regbank #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 8
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  output logic [31:0] prdata,
  input  logic [31:0] stat_i,
  output logic [31:0] ctrl_o
`ifdef APB_SLV_PROT_CHK_EN
  ,
  output logic        proto_err
`endif
);

  localparam int IDX_W = ADDR_W - 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Word indices of the fixed read-only locations (byte 0x80, 0x84, 0x88).
  localparam logic [31:0] WIDX_STATUS = 32'h20;
  localparam logic [31:0] WIDX_WCNT   = 32'h21;
  localparam logic [31:0] WIDX_CYCLE  = 32'h22;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       prdata_q, prdata_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       reg_q [NUM_REGS];

  logic              setup_req;
  logic              capture;
  logic              commit;
  logic              xfer_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_hit;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign setup_req = psel & ~penable;
  assign rd_idx    = paddr[ADDR_W-1:2];
  assign wr_idx    = addr_q[ADDR_W-1:2];
  assign wr_hit    = 32'(wr_idx) < 32'(NUM_REGS);

  // Address bits above ADDR_W-1 alias; byte-lane bits are only checked.
  assign unused_bits = ^{paddr, addr_q};

`ifdef APB_SLV_PROT_CHK_EN
  logic viol;
  logic proto_err_q;
  assign xfer_ok = (paddr[ADDR_W-1:0] == addr_q) && (pwrite == pwrite_q);
`else
  assign xfer_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
`ifdef APB_SLV_PROT_CHK_EN
    viol    = 1'b0;
`endif
    case (state_q)
      ST_SETUP: begin
        if (psel && penable && xfer_ok) begin
          state_d = ST_ACCESS;
          commit  = pwrite_q;
        end else if (setup_req) begin
          state_d = ST_SETUP;
          capture = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
`ifdef APB_SLV_PROT_CHK_EN
        viol = ~psel | ~penable | ~xfer_ok;
`endif
      end
      default: begin
        // IDLE and ACCESS behave alike: only a clean setup phase starts a transfer.
        if (setup_req) begin
          state_d = ST_SETUP;
          capture = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
`ifdef APB_SLV_PROT_CHK_EN
        viol = penable;
`endif
      end
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == 32'(i)) begin
        rd_data = reg_q[i];
      end
    end
    case (32'(rd_idx))
      WIDX_STATUS: rd_data = stat_i;
      WIDX_WCNT:   rd_data = {16'h0, wcnt_q};
      WIDX_CYCLE:  rd_data = cycle_q;
      default:     ;
    endcase
  end

  always_comb begin
    addr_d   = capture ? paddr[ADDR_W-1:0] : addr_q;
    pwrite_d = capture ? pwrite : pwrite_q;
    prdata_d = (capture && !pwrite) ? rd_data : prdata_q;
    wcnt_d   = (commit && wr_hit) ? wcnt_q + 16'd1 : wcnt_q;
    cycle_d  = cycle_q + 32'd1;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      pwrite_q <= 1'b0;
      prdata_q <= 32'h0;
      wcnt_q   <= 16'h0;
      cycle_q  <= 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= 32'h0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pwrite_q <= pwrite_d;
      prdata_q <= prdata_d;
      wcnt_q   <= wcnt_d;
      cycle_q  <= cycle_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_hit && (32'(wr_idx) == 32'(i))) begin
          reg_q[i] <= pwdata;
        end
      end
    end
  end

`ifdef APB_SLV_PROT_CHK_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_q | viol;
    end
  end

  assign proto_err = proto_err_q;
`endif

  assign prdata = prdata_q;
  assign ctrl_o = reg_q[0];

endmodule
`default_nettype wire

// File: tb/tb_apb_slv_regbank.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_slv_regbank
// Brief   : Directed, table-driven bench for apb_slv_regbank.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_slv_regbank;

  localparam logic [31:0] STAT = 32'hA5C3_0F1E;

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic [31:0] stat_i;
  logic [31:0] ctrl_o;
`ifdef APB_SLV_PROT_CHK_EN
  logic        proto_err;
`endif

  int total = 0;
  int bad   = 0;

  apb_slv_regbank #(.NUM_REGS(8), .ADDR_W(8)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .prdata  (prdata),
    .stat_i  (stat_i),
    .ctrl_o  (ctrl_o)
`ifdef APB_SLV_PROT_CHK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the access edge.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge pclk);
    penable = 1'b1;
    rdata   = prdata;
    @(negedge pclk);
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] c1;
  logic [31:0] c2;

  initial begin
    vecs[0]  = '{1'b0, 32'h00,  32'h0,         32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h84,  32'h0,         32'h1,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h80,  32'h1234,      32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b1, 32'h40,  32'h1234,      32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h80,  32'h0,         STAT,         32'hDEADBEEF};
    vecs[5]  = '{1'b0, 32'h40,  32'h0,         32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b0, 32'h84,  32'h0,         32'h1,        32'hDEADBEEF};
    vecs[7]  = '{1'b1, 32'h1C,  32'hCAFEF00D,  32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b0, 32'h11C, 32'h0,         32'hCAFEF00D, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 32'h104, 32'h0BADF00D,  32'h0,        32'hDEADBEEF};
    vecs[10] = '{1'b0, 32'h04,  32'h0,         32'h0BADF00D, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 32'h84,  32'h0,         32'h3,        32'hDEADBEEF};
    vecs[12] = '{1'b0, 32'h20,  32'h0,         32'h0,        32'hDEADBEEF};
    vecs[13] = '{1'b0, 32'h8C,  32'h0,         32'h0,        32'hDEADBEEF};

    preset  = 1'b1;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    pwrite  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    stat_i  = STAT;

    repeat (3) @(negedge pclk);
    check("reset_prdata", prdata, 32'h0);
    check("reset_ctrl", ctrl_o, 32'h0);
`ifdef APB_SLV_PROT_CHK_EN
    check("reset_proto_err", {31'h0, proto_err}, 32'h0);
`endif
    preset = 1'b0;

    // Reset values after five idle cycles.
    idle(5);
    xfer(1'b0, 32'h00, 32'h0, rd); check("rd_reg0_init", rd, 32'h0);
    xfer(1'b0, 32'h84, 32'h0, rd); check("rd_wcnt_init", rd, 32'h0);
    xfer(1'b0, 32'h10, 32'h0, rd); check("rd_reg4_init", rd, 32'h0);
    xfer(1'b0, 32'h88, 32'h0, rd); check("rd_cycle_init", rd, 32'd11);
    check("ctrl_init", ctrl_o, 32'h0);

    // Write to REG[0]: ctrl_o must not change before the commit edge.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'hDEADBEEF;
    @(negedge pclk);
    penable = 1'b1;
    check("ctrl_before_commit", ctrl_o, 32'h0);
    @(negedge pclk);
    check("ctrl_after_commit", ctrl_o, 32'hDEADBEEF);

    // Table rows run back-to-back, starting with a read of the register just written.
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
      if (!vecs[i].wr) begin
        check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      end
      check($sformatf("vec%0d_ctrl", i), ctrl_o, vecs[i].exp_ctrl);
    end
    idle(2);

    // Reset asserted during the access cycle of a write drops the write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55;
    @(negedge pclk);
    penable = 1'b1;
    preset  = 1'b1;
    @(negedge pclk);
    check("rst_mid_ctrl", ctrl_o, 32'h0);
    check("rst_mid_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0; preset = 1'b0;
    idle(2);
    xfer(1'b0, 32'h04, 32'h0, rd); check("rst_mid_reg1", rd, 32'h0);
    xfer(1'b0, 32'h84, 32'h0, rd); check("rst_mid_wcnt", rd, 32'h0);

    // Malformed: psel dropped in the access cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h66;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b1;
    @(negedge pclk);
    // Malformed: penable raised with no setup phase.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h77;
    repeat (2) @(negedge pclk);
    idle(1);
    xfer(1'b0, 32'h08, 32'h0, rd); check("malformed_reg2", rd, 32'h0);
    xfer(1'b0, 32'h84, 32'h0, rd); check("malformed_wcnt", rd, 32'h0);

    // 0x10000 writes wrap the 16-bit write counter back to zero.
    for (int n = 0; n < 65536; n++) begin
      xfer(1'b1, 32'h04, 32'(n), rd);
    end
    xfer(1'b0, 32'h84, 32'h0, rd); check("wcnt_wrap", rd, 32'h0);
    xfer(1'b0, 32'h04, 32'h0, rd); check("reg1_last", rd, 32'h0000FFFF);

    // Two cycle-counter reads 10 idle cycles apart.
    xfer(1'b0, 32'h88, 32'h0, c1);
    idle(10);
    xfer(1'b0, 32'h88, 32'h0, c2);
    check("cycle_delta", c2 - c1, 32'd12);

`ifdef APB_SLV_PROT_CHK_EN
    do_reset();
    idle(2);
    check("prot_clean", {31'h0, proto_err}, 32'h0);
    // Address changes between setup and access.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h77;
    @(negedge pclk);
    penable = 1'b1; paddr = 32'h04;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    check("prot_set", {31'h0, proto_err}, 32'h1);
    idle(3);
    check("prot_held", {31'h0, proto_err}, 32'h1);
    xfer(1'b0, 32'h00, 32'h0, rd); check("prot_reg0", rd, 32'h0);
    xfer(1'b0, 32'h04, 32'h0, rd); check("prot_reg1", rd, 32'h0);
    xfer(1'b1, 32'h08, 32'h99, rd);
    xfer(1'b0, 32'h08, 32'h0, rd); check("prot_after_legal", rd, 32'h99);
    check("prot_still_set", {31'h0, proto_err}, 32'h1);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_slv_regbank.md
Name: apb_slv_regbank

Overview:
- APB (no PREADY/PSLVERR) responder: the slave end for the bus master driving paddr/pwdata/pwrite/psel/penable.
- Provides NUM_REGS read/write registers, a read-only status word, a write counter and a free-running cycle counter.
- Tracks setup/access phases with an FSM. Every transfer completes in exactly two cycles, with no wait states.
- Sits on the peripheral side of the testbench and DUT fabric. Register 0 drives ctrl_o into downstream logic.

Parameters:
- NUM_REGS, 8, number of R/W registers at word offsets 0x00..(NUM_REGS-1)*4; legal range 1..32.
- ADDR_W, 8, number of paddr bits decoded (byte address). Bits [ADDR_W-1:2] select the word; bits above ADDR_W-1 are ignored (aliasing).

Ports:
- pclk  input  1  bus clock, all logic on rising edge
- preset  input  1  asynchronous, active-high reset
- paddr  input  32  byte address
- pwdata  input  32  write data
- pwrite  input  1  1=write, 0=read
- psel  input  1  slave select
- penable  input  1  access-phase strobe
- prdata  output  32  read data, registered
- stat_i  input  32  status word, visible read-only at 0x80
- ctrl_o  output  32  current contents of REG[0]
- proto_err  output  1  sticky protocol-violation flag (only with APB_SLV_PROT_CHK_EN)

Behaviour:
- Reset is asynchronous and active-high on preset; clock is pclk. While preset=1: all REG[i]=0, WCNT=0, CYCLE=0, prdata=0, ctrl_o=0, proto_err=0, FSM=IDLE.
- Deasserting preset mid-transfer drops the transfer; no write occurs.
- FSM states: IDLE, SETUP, ACCESS. State is evaluated at each rising edge.
  - IDLE: psel=1 && penable=0 -> SETUP; capture paddr and pwrite. Otherwise stay in IDLE.
  - SETUP: psel=1 && penable=1 -> ACCESS; the transfer completes at this edge. If write, commit pwdata at this edge.
  - ACCESS: psel=1 && penable=0 -> SETUP (back-to-back transfer, capture again). Otherwise -> IDLE.
- Read data:
  - prdata loads on the edge that enters SETUP with pwrite=0, so it is valid through the access cycle.
  - prdata holds its value until the next read setup. Write transfers leave prdata unchanged.
- Address map (word offset = paddr[ADDR_W-1:2]):
  - 0x00..(NUM_REGS-1)*4: REG[i], R/W.
  - 0x80 STATUS: read returns stat_i sampled at the setup edge; writes ignored.
  - 0x84 WCNT: {16'h0, wcnt[15:0]}; read-only.
  - 0x88 CYCLE: 32-bit count of pclk edges since reset; read-only.
  - All other offsets read 32'h0; writes ignored.
- WCNT: increments by 1 on each committed write to a REG[i] only, and wraps from 0xFFFF to 0.
- CYCLE: increments every clock and wraps from 0xFFFFFFFF to 0. A read returns the value held at the setup edge.
- A write to REG[i] is visible one cycle later: ctrl_o updates the cycle after the commit edge. A back-to-back read of the same register returns the new value.
- Malformed sequences never commit a write. Examples: in SETUP, psel dropped or penable low; penable=1 in IDLE. Either the FSM returns to IDLE, or, if psel=1 && penable=0, it re-enters SETUP and re-captures.

Optional Feature:
- APB_SLV_PROT_CHK_EN defined:
  - proto_err port exists. It is set on any of:
    - (a) penable=1 while the state is IDLE or ACCESS without a preceding setup;
    - (b) in SETUP, psel=0 or penable=0;
    - (c) in SETUP, paddr or pwrite differs from the captured value.
  - On any violation the transfer aborts with no write.
  - proto_err stays 1 until preset.
- Undefined: port and checking logic are absent. Malformed sequences are still aborted as described under Behaviour.

Test Plan:
- Reset then idle 5 cycles, then read 0x00, 0x84 and 0x10 -> prdata=0 each time; ctrl_o=0.
- Write 0xDEADBEEF to 0x00, then read it back-to-back -> prdata=0xDEADBEEF in the access cycle; ctrl_o=0xDEADBEEF from the cycle after commit; WCNT reads 1.
- Write 0x1234 to 0x80 and to 0x40 (unmapped when NUM_REGS=8), then read both -> 0x80 returns stat_i and 0x40 returns 0; WCNT unchanged.
- 0x10000 writes to REG[1] -> WCNT reads 0; two CYCLE reads 10 idle cycles apart differ by 12 (10 idle cycles + 2-cycle transfer).
- Assert preset during the access cycle of a write of 0x55 to 0x04 -> REG[1] stays 0 and WCNT stays 0 after reset release.
- With APB_SLV_PROT_CHK_EN: drive setup to 0x00, then change paddr to 0x04 at access -> no write, proto_err=1 and held; a following legal transfer still completes.
